// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control tokens, word-alignment FSM state
// type and a ones-count helper used by both the encoder and the decoder.
package tmds_pkg;

    localparam logic [9:0] CTRLTOKEN_0 = 10'b1101010100;
    localparam logic [9:0] CTRLTOKEN_1 = 10'b0010101011;
    localparam logic [9:0] CTRLTOKEN_2 = 10'b0101010100;
    localparam logic [9:0] CTRLTOKEN_3 = 10'b1010101011;

    typedef logic [1:0] align_state_t;
    localparam align_state_t ST_SEARCH  = 2'd0;
    localparam align_state_t ST_SLIP    = 2'd1;
    localparam align_state_t ST_ALIGNED = 2'd2;

    function automatic logic [3:0] ones10(input logic [9:0] w);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, w[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word-boundary alignment FSM: counts control-token runs from stage 1, requests
// bit-slips when tokens stay absent, and tracks lock loss in ALIGNED.
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN     = 8,
    parameter int SEARCH_LEN   = 64,
    parameter int SLIP_WAIT    = 4,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_tok_vld,
    output logic o_bitslip,
    output logic o_aligned
);

    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int MISS_W = $clog2(SEARCH_LEN + 1);
    localparam int SLIP_W = $clog2(SLIP_WAIT + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    align_state_t      r_state;
    logic [RUN_W-1:0]  r_run;
    logic [MISS_W-1:0] r_miss;
    logic [SLIP_W-1:0] r_slip;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_bitslip;

    // Each threshold is acted on as the counter would reach it, so counters
    // never pass their limit; a token in the same cycle always takes priority.
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_state   <= ST_SEARCH;
            r_run     <= '0;
            r_miss    <= '0;
            r_slip    <= '0;
            r_tmo     <= '0;
            r_bitslip <= 1'b0;
        end else begin
            r_bitslip <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    if (i_tok_vld) begin
                        r_miss <= '0;
                        if (r_run == RUN_W'(CTRL_RUN - 1)) begin
                            r_state <= ST_ALIGNED;
                            r_run   <= '0;
                            r_tmo   <= '0;
                        end else begin
                            r_run <= r_run + RUN_W'(1);
                        end
                    end else begin
                        r_run <= '0;
                        if (r_miss == MISS_W'(SEARCH_LEN - 1)) begin
                            r_state   <= ST_SLIP;
                            r_bitslip <= 1'b1;
                            r_slip    <= '0;
                            r_miss    <= '0;
                        end else begin
                            r_miss <= r_miss + MISS_W'(1);
                        end
                    end
                end
                ST_SLIP: begin
                    if (r_slip == SLIP_W'(SLIP_WAIT)) begin
                        r_state <= ST_SEARCH;
                        r_run   <= '0;
                        r_miss  <= '0;
                    end else begin
                        r_slip <= r_slip + SLIP_W'(1);
                    end
                end
                ST_ALIGNED: begin
                    if (i_tok_vld) begin
                        r_tmo <= '0;
                    end else if (r_tmo == TMO_W'(LOCK_TIMEOUT - 1)) begin
                        r_state <= ST_SEARCH;
                        r_run   <= '0;
                        r_miss  <= '0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

    assign o_bitslip = r_bitslip;
    assign o_aligned = (r_state == ST_ALIGNED);

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: 2-stage pipeline (din register + token match, then decode).
// Optional disparity error counter enabled by TMDS_DEC_ERRCNT_EN.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN     = 8,
    parameter int SEARCH_LEN   = 64,
    parameter int SLIP_WAIT    = 4,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  din,
    output logic        bitslip,
    output logic        aligned,
    output logic [7:0]  dout,
    output logic        de,
    output logic        c0,
    output logic        c1
`ifdef TMDS_DEC_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    logic       w_tok_vld;
    logic [1:0] w_tok_code;
    logic [9:0] r_din;
    logic       r_tok_vld;
    logic [1:0] r_tok_code;
    logic [7:0] w_d;
    logic [7:0] w_q;

    always_comb begin
        w_tok_vld  = 1'b1;
        w_tok_code = 2'b00;
        case (din)
            CTRLTOKEN_0: w_tok_code = 2'b00;
            CTRLTOKEN_1: w_tok_code = 2'b01;
            CTRLTOKEN_2: w_tok_code = 2'b10;
            CTRLTOKEN_3: w_tok_code = 2'b11;
            default:     w_tok_vld  = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_din      <= '0;
            r_tok_vld  <= 1'b0;
            r_tok_code <= 2'b00;
        end else begin
            r_din      <= din;
            r_tok_vld  <= w_tok_vld;
            r_tok_code <= w_tok_code;
        end
    end

    // din[9] undoes the encoder's inversion; din[8] selects XOR vs XNOR chaining.
    always_comb begin
        w_d    = r_din[9] ? ~r_din[7:0] : r_din[7:0];
        w_q    = 8'd0;
        w_q[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_q[i] = r_din[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            dout <= 8'd0;
            de   <= 1'b0;
            c0   <= 1'b0;
            c1   <= 1'b0;
        end else if (r_tok_vld) begin
            de <= 1'b0;
            c1 <= r_tok_code[1];
            c0 <= r_tok_code[0];
        end else begin
            de   <= 1'b1;
            dout <= w_q;
        end
    end

    tmds_word_align #(
        .CTRL_RUN     (CTRL_RUN),
        .SEARCH_LEN   (SEARCH_LEN),
        .SLIP_WAIT    (SLIP_WAIT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_align (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_tok_vld (r_tok_vld),
        .o_bitslip (bitslip),
        .o_aligned (aligned)
    );

`ifdef TMDS_DEC_ERRCNT_EN
    logic signed [5:0] r_disp;
    logic signed [7:0] w_delta;
    logic signed [7:0] w_sum;
    logic              w_over;
    logic signed [5:0] w_disp_nxt;

    // Accumulator is clamped rather than wrapped while unlocked sums run away.
    always_comb begin
        w_delta    = $signed({3'b000, ones10(r_din), 1'b0}) - 8'sd10;
        w_sum      = $signed({{2{r_disp[5]}}, r_disp}) + w_delta;
        w_over     = (w_sum > 8'sd16) || (w_sum < -8'sd16);
        w_disp_nxt = w_sum[5:0];
        if (w_sum > 8'sd31) begin
            w_disp_nxt = 6'sd31;
        end else if (w_sum < -8'sd32) begin
            w_disp_nxt = $signed(6'b100000);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            r_disp  <= '0;
            err_cnt <= 16'd0;
        end else if (r_tok_vld) begin
            r_disp <= '0;
        end else if (aligned && w_over) begin
            r_disp <= '0;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end else begin
            r_disp <= w_disp_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboarded bench for tmds_decoder: randomized words against a behavioural
// decode model, plus alignment, bit-slip and lock-timeout scenarios.
module tb_tmds_decoder;
    import tmds_pkg::*;

    localparam int SLIP_GAP = 64 + 4 + 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  din;
    logic        bitslip, aligned, de, c0, c1;
    logic [7:0]  dout;
`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    typedef struct packed {
        logic [7:0] dout;
        logic       de;
        logic       c1;
        logic       c0;
    } exp_t;

    typedef struct {
        exp_t e;
        int   due;
    } sb_t;

    sb_t        sb_q[$];
    sb_t        mon_s;
    logic [9:0] toks [4];
    logic [7:0] m_dout;
    logic [1:0] m_c;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    tmds_decoder dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (din),
        .bitslip   (bitslip),
        .aligned   (aligned),
        .dout      (dout),
        .de        (de),
        .c0        (c0),
        .c1        (c1)
`ifdef TMDS_DEC_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: token lookup, otherwise undo inversion and rebuild each bit
    // from whether neighbouring bits of d are equal.
    task automatic push(input logic [9:0] w);
        sb_t s;
        int  k, dv, q, differ;
        k = -1;
        for (int j = 0; j < 4; j++) if (w == toks[j]) k = j;
        if (k >= 0) begin
            m_c    = 2'(k);
            s.e.de = 1'b0;
        end else begin
            dv = w[9] ? (255 - int'(w[7:0])) : int'(w[7:0]);
            q  = dv % 2;
            for (int i = 1; i < 8; i++) begin
                differ = (((dv >> i) % 2) != ((dv >> (i - 1)) % 2)) ? 1 : 0;
                if ((w[8] == 1'b1) == (differ == 1)) q = q + (1 << i);
            end
            m_dout = 8'(q);
            s.e.de = 1'b1;
        end
        s.e.dout = m_dout;
        s.e.c1   = m_c[1];
        s.e.c0   = m_c[0];
        s.due    = cyc + 2;
        sb_q.push_back(s);
    endtask

    task automatic drive_now(input logic [9:0] w);
        din = w;
        push(w);
    endtask

    task automatic drive(input logic [9:0] w);
        @(negedge sys_clk);
        drive_now(w);
    endtask

    function automatic logic [9:0] rnd_data();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        while (w == toks[0] || w == toks[1] || w == toks[2] || w == toks[3])
            w = 10'($urandom_range(0, 1023));
        return w;
    endfunction

    function automatic logic [9:0] rot_word(input int o);
        logic [19:0] s;
        s = {toks[1], toks[1]};
        return s[o +: 10];
    endfunction

    task automatic do_reset();
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        sb_q.delete();
        m_dout = 8'd0;
        m_c    = 2'b00;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_de_c", {de, c1, c0}, 0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_aligned", aligned, 0);
`ifdef TMDS_DEC_ERRCNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        din = 10'd0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        drive_now(10'd0);
    endtask

    always @(posedge sys_clk) begin
        #2;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_s = sb_q.pop_front();
            chk("decode{dout,de,c1,c0}", {dout, de, c1, c0}, mon_s.e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int off, nslip, last;
        toks[0] = CTRLTOKEN_0;
        toks[1] = CTRLTOKEN_1;
        toks[2] = CTRLTOKEN_2;
        toks[3] = CTRLTOKEN_3;
        sys_rst_n = 1'b1;
        din = 10'd0;
        m_dout = 8'd0;
        m_c = 2'b00;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            drive(toks[0]);
            if (i == 8) chk("align_early", aligned, 0);
            if (i == 9) chk("align_rise", aligned, 1);
        end
        chk("align_ctrl{c1,c0,de}", {c1, c0, de}, 3'b000);

`ifdef TMDS_DEC_ERRCNT_EN
        for (int i = 0; i < 9; i++) begin
            drive(10'h3FF);
            if (i == 3) chk("errcnt_first", err_cnt, 1);
        end
        repeat (2) drive(toks[0]);
        chk("errcnt_total", err_cnt, 4);
`endif

        drive(10'h100);
        drive(10'h200);
        repeat (2) drive(toks[0]);

        repeat (4095) drive(rnd_data());
        drive(toks[2]);
        repeat (4096) drive(rnd_data());
        drive(rnd_data());
        chk("tmo_hold", aligned, 1);
        drive(rnd_data());
        chk("tmo_drop", aligned, 0);

        for (int i = 0; i < 200; i++) begin
            if (i == 100) do_reset();
            if ($urandom_range(0, 3) == 0) drive(toks[$urandom_range(0, 3)]);
            else drive(10'($urandom_range(0, 1023)));
        end

`ifdef TMDS_DEC_ERRCNT_EN
        do_reset();
        repeat (9) drive(10'h3FF);
        repeat (2) drive(toks[0]);
        chk("errcnt_unaligned", err_cnt, 0);
`endif

        do_reset();
        off = 3;
        nslip = 0;
        last = -1;
        for (int n = 0; n < 1500 && !aligned; n++) begin
            @(negedge sys_clk);
            if (bitslip) begin
                if (last >= 0) chk("slip_gap", cyc - last, SLIP_GAP);
                last = cyc;
                nslip++;
                off = (off + 1) % 10;
            end
            drive_now(rot_word(off));
        end
        chk("slip_count", nslip, 7);
        chk("slip_aligned", aligned, 1);
        repeat (3) drive(rot_word(off));
        chk("slip_ctrl{c1,c0}", {c1, c0}, 2'b01);

        repeat (4) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
